perceptron_serial_trainable: RTL

//  Parametrised successor to the fixed single-output perceptron: binary input vector, signed
//  per-input weights plus bias, evaluated by a serial multiply-accumulate (one input per cycle).

---
 rtl/perceptron_serial_trainable.sv | 126 ++++++++++++
 1 files changed

// File: rtl/perceptron_serial_trainable.sv
// Serial perceptron with binary inputs and signed weights plus bias. Inputs are accumulated one per cycle.
// An optional online rule (lr=1, saturating) updates the weights when the result differs from the target.
module perceptron_serial_trainable #(
    parameter int N_IN  = 8,
    parameter int W_W   = 4,
    parameter int ERR_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_IN-1:0]              x,
    input  logic                         train,
    input  logic                         target,
    input  logic                         wld_en,
    input  logic [$clog2(N_IN+1)-1:0]    wld_idx,
    input  logic [W_W-1:0]               wld_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         result,
    output logic                         err,
    output logic [ERR_W-1:0]             err_cnt
);

    localparam int IDX_W = $clog2(N_IN + 1);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int ACC_W = W_W + $clog2(N_IN + 1) + 1;

    localparam logic signed [W_W-1:0]   W_MAX    = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [W_W-1:0]   W_MIN    = {1'b1, {(W_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST     = CNT_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]        BIAS_IDX = IDX_W'(N_IN);
    localparam logic signed [ACC_W-1:0] ZERO     = '0;

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, DONE} state_t;

    state_t                  state, state_nx;
    logic signed [W_W-1:0]   w [N_IN];
    logic signed [W_W-1:0]   bias;
    logic [N_IN-1:0]         x_l;
    logic                    train_l, target_l;
    logic [CNT_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc, sum;
    logic                    res_nx, err_nx, learn, wld_ok;

    // Step by one toward the target class, holding at the representable limits.
    function automatic logic signed [W_W-1:0] sat_step(input logic signed [W_W-1:0] v,
                                                       input logic up);
        if (up) return (v == W_MAX) ? v : v + W_W'(1);
        return (v == W_MIN) ? v : v - W_W'(1);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)    state_nx = ACCUM;
            ACCUM:   if (idx == LAST) state_nx = DECIDE;
            DECIDE:                   state_nx = DONE;
            DONE:    if (out_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum    = acc + ACC_W'(bias);
        res_nx = (sum >= ZERO);
        err_nx = train_l & (res_nx != target_l);
        learn  = (state == DECIDE) & err_nx;
        wld_ok = (state == IDLE) & wld_en & ~in_valid;
    end

    // NOTE: the weight file is a handful of flops and must read as zero after reset, so it is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_l      <= '0;
            train_l  <= 1'b0;
            target_l <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            result   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            bias     <= '0;
            for (int k = 0; k < N_IN; k++) w[k] <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    x_l      <= x;
                    train_l  <= train;
                    target_l <= target;
                    acc      <= '0;
                    idx      <= '0;
                end
                ACCUM: begin
                    if (x_l[idx]) acc <= acc + ACC_W'(w[idx]);
                    idx <= idx + CNT_W'(1);
                end
                DECIDE: begin
                    result <= res_nx;
                    err    <= err_nx;
                    if (err_nx && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                end
                default: ;
            endcase

            // Loads only happen in IDLE and learning only in DECIDE, so the two never collide.
            for (int k = 0; k < N_IN; k++) begin
                if (wld_ok && wld_idx == IDX_W'(k)) w[k] <= wld_data;
                else if (learn && x_l[k])          w[k] <= sat_step(w[k], target_l);
            end
            if (wld_ok && wld_idx == BIAS_IDX) bias <= wld_data;
            else if (learn)                    bias <= sat_step(bias, target_l);
        end
    end

endmodule
